alu_sequencer: RTL and testbench

//  Initiator/driver for the 4-bit combinational ALU (A, B, OP -> Out, Extra).

---
 rtl/alu_sequencer_if.sv | 32 +++
 rtl/alu_sequencer.sv | 112 +++++++++++
 tb/tb_alu_sequencer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Command, ALU and response signal bundle for alu_sequencer.
// master = sequencer side; slave = command source, ALU and response consumer side.
interface alu_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [1:0] cmd_op;

  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_op;
  logic [3:0] alu_out;
  logic       alu_extra;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_out;
  logic       rsp_extra;
  logic [1:0] rsp_op;
  logic       rsp_err;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_out, alu_extra, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_out, rsp_extra, rsp_op, rsp_err
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_out, alu_extra, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_out, rsp_extra, rsp_op, rsp_err
  );
endinterface

// File: rtl/alu_sequencer.sv
// Drives one operation at a time into a combinational 4-bit ALU, waits a settle
// time, captures the result and queues it in a response FIFO.
module alu_sequencer #(
  parameter int DEPTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_sequencer_if.master bus,
  output logic            busy,
  output logic [7:0]      ops_count,
  output logic [1:0]      dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // ready never depends on valid, and valid may drop without a transfer.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;

  localparam logic [AW:0]   FULL        = (AW + 1)'(DEPTH);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

  logic [1:0]    state;
  logic [SW-1:0] settle_cnt;
  logic [3:0]    a_q, b_q;
  logic [1:0]    op_q;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic       accept, push, pop, err;
  logic [7:0] push_data, head;

  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign push   = (state == CAPTURE);
  assign pop    = bus.rsp_valid && bus.rsp_ready;

  // Divide by zero: the ALU output is meaningless, so store zeros instead.
  assign err       = (op_q == 2'b10) && (b_q == 4'd0);
  assign push_data = {op_q, err, err ? 1'b0 : bus.alu_extra, err ? 4'h0 : bus.alu_out};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      ops_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q        <= bus.cmd_a;
            b_q        <= bus.cmd_b;
            op_q       <= bus.cmd_op;
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) state <= CAPTURE;
          else settle_cnt <= settle_cnt - 1'b1;
        end
        CAPTURE: begin
          ops_count <= ops_count + 8'd1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Space for the push is guaranteed: a command is only accepted when the FIFO has room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head          = mem[rd_ptr];
  assign bus.rsp_valid = (count != '0);
  assign bus.rsp_op    = head[7:6];
  assign bus.rsp_err   = head[5];
  assign bus.rsp_extra = head[4];
  assign bus.rsp_out   = head[3:0];

  assign bus.cmd_ready = (state == IDLE) && (count < FULL);
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_op    = op_q;
  assign busy          = (state != IDLE);
  assign dbg_state     = state;
endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized and directed stimulus for alu_sequencer; responses checked by a
// scoreboard fed from an arithmetic reference model at command acceptance.
module tb_alu_sequencer;
  localparam int DEPTH  = 4;
  localparam int SETTLE = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic [7:0] ops_count;
  logic [1:0] dbg_state;

  alu_sequencer_if bus ();

  alu_sequencer #(.DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.master),
    .busy      (busy),
    .ops_count (ops_count),
    .dbg_state (dbg_state)
  );

  // Clock/reset
  always #5 clk = ~clk;

  // Environment ALU; divide by zero returns junk that the sequencer must ignore.
  logic [4:0] alu_r;
  always_comb begin
    alu_r = '0;
    case (bus.alu_op)
      2'b00: alu_r = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      2'b01: alu_r = 5'({4'b0, bus.alu_a} * {4'b0, bus.alu_b});
      2'b10: alu_r = (bus.alu_b == 4'd0) ? 5'h1F : {1'b0, bus.alu_a / bus.alu_b};
      default: alu_r = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
    endcase
    bus.alu_out   = alu_r[3:0];
    bus.alu_extra = alu_r[4];
  end

  int         n_checks = 0;
  int         n_fail = 0;
  int         total_acc = 0;
  int         busy_cycles = 0;
  bit         rand_rdy = 1'b0;
  logic [7:0] exp_q[$];
  logic [9:0] hold;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: {op, err, extra, out} from plain integer arithmetic mod 32.
  function automatic logic [7:0] ref_rsp(input int a, input int b, input int op);
    int   r;
    logic e;
    e = (op == 2) && (b == 0);
    case (op)
      0: r = a + b;
      1: r = a * b;
      2: r = e ? 0 : a / b;
      default: r = a - b;
    endcase
    r = ((r % 32) + 32) % 32;
    return {op[1:0], e, 5'(r)};
  endfunction

  // Scoreboard and monitor
  initial begin
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        total_acc   = 0;
        busy_cycles = 0;
      end else begin
        if (busy) begin
          busy_cycles++;
          chk("alu_hold", 32'({bus.alu_a, bus.alu_b, bus.alu_op}), 32'(hold));
        end else if (busy_cycles != 0) begin
          chk("busy_span", 32'(busy_cycles), 32'(SETTLE + 1));
          busy_cycles = 0;
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_unexpected: got 0x%0h with empty scoreboard at %0t",
                     {bus.rsp_op, bus.rsp_err, bus.rsp_extra, bus.rsp_out}, $time);
          end else begin
            exp = exp_q.pop_front();
            chk("rsp", 32'({bus.rsp_op, bus.rsp_err, bus.rsp_extra, bus.rsp_out}), 32'(exp));
          end
        end
        if (bus.cmd_valid && bus.cmd_ready) begin
          exp_q.push_back(ref_rsp(int'(bus.cmd_a), int'(bus.cmd_b), int'(bus.cmd_op)));
          hold = {bus.cmd_a, bus.cmd_b, bus.cmd_op};
          total_acc++;
        end
      end
    end
  end

  // Driver tasks
  task automatic drive_cmd(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    @(posedge clk); #1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_op    = op;
    bus.cmd_valid = 1'b1;
  endtask

  task automatic wait_accept(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (rand_rdy) bus.rsp_ready = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = 4'($urandom);
    bus.cmd_b     = 4'($urandom);
    bus.cmd_op    = 2'($urandom);
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    bit ok;
    drive_cmd(a, b, op);
    wait_accept(300, ok);
    chk("cmd_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !bus.rsp_valid) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain", 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    chk("idle", 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit seen;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_op    = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_op}), 32'd0);
    chk("rst_ops_count", 32'(ops_count), 32'd0);
    chk("rst_rsp_fields", 32'({bus.rsp_op, bus.rsp_err, bus.rsp_extra, bus.rsp_out}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed arithmetic cases
    bus.rsp_ready = 1'b1;
    send(4'd7, 4'd9, 2'b00);
    wait_drain(50);
    chk("ops_after_add", 32'(ops_count), 32'd1);
    send(4'd3, 4'd5, 2'b01);
    send(4'd3, 4'd5, 2'b11);
    send(4'd9, 4'd0, 2'b10);
    send(4'd9, 4'd2, 2'b10);
    wait_drain(50);
    chk("ops_directed", 32'(ops_count), 32'(total_acc));

    // Back-pressure: four accepted, fifth held until one pop
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(4'($urandom), 4'($urandom), 2'($urandom));
    drive_cmd(4'd12, 4'd3, 2'b11);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_cmd_ready_low", 32'(bus.cmd_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    wait_accept(20, ok);
    chk("bp_fifth_accepted", 32'(ok), 32'd1);
    bus.rsp_ready = 1'b1;
    wait_drain(100);

    // Push and pop on the same edge with three entries queued
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(4'($urandom), 4'($urandom), 2'($urandom));
    wait_idle(20);
    send(4'd6, 4'd7, 2'b01);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (dbg_state == 2'd2) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("capture_seen", 32'(seen), 32'd1);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("pushpop_busy", 32'(busy), 32'd0);
    chk("pushpop_room_left", 32'(bus.cmd_ready), 32'd1);
    send(4'd1, 4'd1, 2'b00);
    wait_idle(20);
    chk("fifo_now_full", 32'(bus.cmd_ready), 32'd0);
    bus.rsp_ready = 1'b1;
    wait_drain(100);

    // Random traffic up to exactly 256 completed operations
    rand_rdy = 1'b1;
    while (total_acc < 256) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send(4'($urandom), 4'($urandom), 2'($urandom));
    end
    rand_rdy = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_drain(200);
    chk("ops_wrap", 32'(ops_count), 32'd0);

    // Reset while an operation settles with two results queued
    bus.rsp_ready = 1'b0;
    send(4'd2, 4'd3, 2'b00);
    send(4'd8, 4'd4, 2'b10);
    wait_idle(20);
    send(4'd5, 4'd5, 2'b01);
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_op}), 32'd0);
    chk("midrst_ops_count", 32'(ops_count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    send(4'd4, 4'd4, 2'b01);
    wait_drain(50);
    chk("post_rst_ops_count", 32'(ops_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
